// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding, vectors.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package irq_ctrl_pkg;

   localparam int SRC_CNT = 8;

   localparam logic [7:0] DEF_VEC_RESET    = 8'h40;
   localparam logic [7:0] DEF_SPURIOUS_VEC = 8'h18;

   // Word indices, taken from addr[7:1]
   localparam logic [6:0] REG_PENDING  = 7'd0;
   localparam logic [6:0] REG_ENABLE   = 7'd1;
   localparam logic [6:0] REG_VBASE    = 7'd2;
   localparam logic [6:0] REG_LEVEL_LO = 7'd3;
   localparam logic [6:0] REG_LEVEL_HI = 7'd4;

   // IACK sequencer states
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RESOLVE = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;

   // One 3-bit priority level per source
   typedef logic [SRC_CNT-1:0][2:0] lvl_vec_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// 16-bit peripheral bus (uds/lds/rw/ack) used to reach the controller registers.
// Latency: ack and read data arrive one cycle after a strobed cycle.
// Backpressure: none; every strobed cycle is acknowledged unconditionally.
interface irq_ctrl_if;
   logic [15:0] data_write;
   logic [15:0] data_read;
   logic [7:0]  addr;
   logic        uds;
   logic        lds;
   logic        rw;
   logic        ack;

   modport master (output data_write, addr, uds, lds, rw, input data_read, ack);
   modport slave  (input data_write, addr, uds, lds, rw, output data_read, ack);
endinterface

// File: rtl/irq_prio_enc.sv
// Priority encoder: highest level among eligible sources, plus lowest-index source at a target level.
// Latency: combinational.
// Backpressure: none.
module irq_prio_enc
   import irq_ctrl_pkg::*;
(
   input  logic [SRC_CNT-1:0] elig,
   input  lvl_vec_t           lvl,
   input  logic [2:0]         tgt_level,
   output logic [2:0]         max_level,
   output logic               found,
   output logic [2:0]         idx
);

   // Scan high to low so the last hit is the lowest index; level 0 never matches
   always_comb begin
      max_level = 3'd0;
      found     = 1'b0;
      idx       = 3'd0;
      for (int i = SRC_CNT - 1; i >= 0; i--) begin
         if (elig[i] && (lvl[i] > max_level)) begin
            max_level = lvl[i];
         end
         if (elig[i] && (lvl[i] == tgt_level) && (tgt_level != 3'd0)) begin
            found = 1'b1;
            idx   = i[2:0];
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// 68000 interrupt controller: pending latch, mask, per-source level, IPL drive and IACK vectoring.
// Latency: irq pulse -> pending +1 cycle -> ipl_n +2 cycles; IACK vector 2 cycles after iack rises.
// Backpressure: none; bus always acks next cycle, a new IACK needs iack to drop first.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int         NUM_SRC      = SRC_CNT,
   parameter logic [7:0] VEC_RESET    = DEF_VEC_RESET,
   parameter logic [7:0] SPURIOUS_VEC = DEF_SPURIOUS_VEC
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] irq_in,
   irq_ctrl_if.slave          bus,
   output logic [2:0]         ipl_n,
   input  logic               iack,
   input  logic [2:0]         iack_level,
   output logic               iack_ack,
   output logic [7:0]         vector
);

   logic [NUM_SRC-1:0] pending, pend_nx, enable, elig;
   logic [4:0]         base;
   lvl_vec_t           lvl;
   logic [1:0]         state;
   logic [6:0]         word;
   logic               sel, wr, rd;
   logic [15:0]        rdata;
   logic [2:0]         ipl_max, res_idx;
   logic               res_found;
   logic               unused_ipl_found;
   logic [2:0]         unused_ipl_idx, unused_res_max;
   logic               unused_bits;

   assign word = bus.addr[7:1];
   assign sel  = bus.uds | bus.lds;
   assign wr   = sel & ~bus.rw;
   assign rd   = sel & bus.rw;
   assign unused_bits = ^{bus.addr[0], bus.data_write[15], bus.data_write[11]};

   // A source can interrupt only when pending, enabled and given a non-zero level
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         elig[i] = pending[i] & enable[i] & (lvl[i] != 3'd0);
      end
   end

   irq_prio_enc u_ipl_enc (
      .elig      (elig),
      .lvl       (lvl),
      .tgt_level (3'd0),
      .max_level (ipl_max),
      .found     (unused_ipl_found),
      .idx       (unused_ipl_idx)
   );

   irq_prio_enc u_res_enc (
      .elig      (elig),
      .lvl       (lvl),
      .tgt_level (iack_level),
      .max_level (unused_res_max),
      .found     (res_found),
      .idx       (res_idx)
   );

   // Register read mux; unused nibble/low bits read back as zero
   always_comb begin
      rdata = 16'h0000;
      case (word)
         REG_PENDING:  rdata = {8'h00, pending};
         REG_ENABLE:   rdata = {8'h00, enable};
         REG_VBASE:    rdata = {8'h00, base, 3'b000};
         REG_LEVEL_LO: rdata = {1'b0, lvl[3], 1'b0, lvl[2], 1'b0, lvl[1], 1'b0, lvl[0]};
         REG_LEVEL_HI: rdata = {1'b0, lvl[7], 1'b0, lvl[6], 1'b0, lvl[5], 1'b0, lvl[4]};
         default:      rdata = 16'h0000;
      endcase
   end

   // Pending next-state: W1C and IACK clears first, then new pulses win
   always_comb begin
      pend_nx = pending;
      if (wr && bus.lds && (word == REG_PENDING)) begin
         pend_nx = pend_nx & ~bus.data_write[NUM_SRC-1:0];
      end
      if ((state == ST_RESOLVE) && res_found) begin
         pend_nx[res_idx] = 1'b0;
      end
      pend_nx = pend_nx | irq_in;
   end

   // Bus acknowledge and registered read data, byte lanes follow the strobes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.ack       <= 1'b0;
         bus.data_read <= 16'h0000;
      end else begin
         bus.ack <= sel;
         if (rd && bus.uds) bus.data_read[15:8] <= rdata[15:8];
         if (rd && bus.lds) bus.data_read[7:0]  <= rdata[7:0];
      end
   end

   // Configuration register writes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         enable <= '0;
         base   <= VEC_RESET[7:3];
         lvl    <= '0;
      end else if (wr) begin
         if (bus.lds && (word == REG_ENABLE)) enable <= bus.data_write[7:0];
         if (bus.lds && (word == REG_VBASE))  base   <= bus.data_write[7:3];
         if (word == REG_LEVEL_LO) begin
            if (bus.uds) begin
               lvl[3] <= bus.data_write[14:12];
               lvl[2] <= bus.data_write[10:8];
            end
            if (bus.lds) begin
               lvl[1] <= bus.data_write[6:4];
               lvl[0] <= bus.data_write[2:0];
            end
         end
         if (word == REG_LEVEL_HI) begin
            if (bus.uds) begin
               lvl[7] <= bus.data_write[14:12];
               lvl[6] <= bus.data_write[10:8];
            end
            if (bus.lds) begin
               lvl[5] <= bus.data_write[6:4];
               lvl[4] <= bus.data_write[2:0];
            end
         end
      end
   end

   // Pending bits and registered IPL output
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending <= '0;
         ipl_n   <= 3'b111;
      end else begin
         pending <= pend_nx;
         ipl_n   <= ~ipl_max;
      end
   end

   // IACK sequencer: resolve once per iack assertion, pulse iack_ack with the vector
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         iack_ack <= 1'b0;
         vector   <= 8'h00;
      end else begin
         iack_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (iack) state <= ST_RESOLVE;
            end
            ST_RESOLVE: begin
               vector   <= res_found ? {base, res_idx} : SPURIOUS_VEC;
               iack_ack <= 1'b1;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!iack) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: scoreboard queues for bus reads and IACK vectors.
// Latency: checks ipl_n timing and IACK vector arrival against the expected cycle.
// Backpressure: n/a.
module tb_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] irq_in;
   logic [2:0] ipl_n;
   logic       iack;
   logic [2:0] iack_level;
   logic       iack_ack;
   logic [7:0] vector;

   irq_ctrl_if bif ();

   irq_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .irq_in     (irq_in),
      .bus        (bif),
      .ipl_n      (ipl_n),
      .iack       (iack),
      .iack_level (iack_level),
      .iack_ack   (iack_ack),
      .vector     (vector)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int ack_cnt = 0;
   logic prev_rd = 1'b0;
   logic [15:0] rd_q [$];
   logic [7:0]  vec_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Remember which acked cycles were reads
   always @(posedge clk) prev_rd <= (bif.uds | bif.lds) & bif.rw;

   // Monitor: pop expected values when the DUT produces read data or a vector
   always @(negedge clk) begin
      if (bif.ack && prev_rd) begin
         chk("rd_q_nonempty", rd_q.size() != 0, 1);
         if (rd_q.size() != 0) chk("rd_data", bif.data_read, rd_q.pop_front());
      end
      if (iack_ack) begin
         ack_cnt++;
         chk("vec_q_nonempty", vec_q.size() != 0, 1);
         if (vec_q.size() != 0) chk("vector", vector, vec_q.pop_front());
      end
   end

   task automatic bus_wr(input logic [6:0] w, input logic [15:0] d, input logic u, input logic l);
      @(posedge clk); #1;
      bif.addr = {w, 1'b0}; bif.data_write = d; bif.uds = u; bif.lds = l; bif.rw = 1'b0;
      @(posedge clk); #1;
      bif.uds = 1'b0; bif.lds = 1'b0; bif.rw = 1'b1;
   endtask

   task automatic bus_rd(input logic [6:0] w, input logic u, input logic l, input logic [15:0] exp);
      rd_q.push_back(exp);
      @(posedge clk); #1;
      bif.addr = {w, 1'b0}; bif.uds = u; bif.lds = l; bif.rw = 1'b1;
      @(posedge clk); #1;
      bif.uds = 1'b0; bif.lds = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (rd_q.size() == 0) break;
         @(posedge clk); #1;
      end
      if (rd_q.size() != 0) begin
         chk("rd_timeout", rd_q.size(), 0);
         rd_q.delete();
      end
   endtask

   task automatic do_iack(input logic [2:0] lv, input logic [7:0] exp);
      vec_q.push_back(exp);
      @(posedge clk); #1;
      iack = 1'b1; iack_level = lv;
      for (int k = 0; k < 10; k++) begin
         if (vec_q.size() == 0) break;
         @(posedge clk); #1;
      end
      if (vec_q.size() != 0) begin
         chk("iack_timeout", vec_q.size(), 0);
         vec_q.delete();
      end
      repeat (3) @(posedge clk);
      #1 iack = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic pulse_irq(input logic [7:0] m);
      @(posedge clk); #1 irq_in = m;
      @(posedge clk); #1 irq_in = 8'h00;
   endtask

   initial begin
      int cnt0;
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0;
      reset_n = 1'b0; irq_in = 8'h00; iack = 1'b0; iack_level = 3'd0;
      bif.addr = 8'h00; bif.data_write = 16'h0000; bif.uds = 1'b0; bif.lds = 1'b0; bif.rw = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ipl", ipl_n, 3'b111);
      chk("rst_ack", bif.ack, 1'b0);
      chk("rst_iack_ack", iack_ack, 1'b0);
      chk("rst_vector", vector, 8'h00);
      chk("rst_data_read", bif.data_read, 16'h0000);
      reset_n = 1'b1;

      // Reset values of the register map
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0000);
      bus_rd(7'd1, 1'b1, 1'b1, 16'h0000);
      bus_rd(7'd2, 1'b1, 1'b1, 16'h0040);
      bus_rd(7'd3, 1'b1, 1'b1, 16'h0000);
      bus_rd(7'd4, 1'b1, 1'b1, 16'h0000);
      bus_rd(7'd5, 1'b1, 1'b1, 16'h0000);

      // Single source at level 5: exact ipl_n latency
      bus_wr(7'd3, 16'h0005, 1'b0, 1'b1);
      bus_wr(7'd1, 16'h0001, 1'b0, 1'b1);
      @(posedge clk); #1 irq_in = 8'h01;
      @(posedge clk); #1 irq_in = 8'h00;
      @(negedge clk);
      chk("ipl_n_plus1", ipl_n, 3'b111);
      @(negedge clk);
      chk("ipl_n_plus2", ipl_n, 3'b010);
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0001);
      bus_wr(7'd0, 16'h0001, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("ipl_after_w1c", ipl_n, 3'b111);

      // Two sources at level 5: lowest index first
      bus_wr(7'd3, 16'h0550, 1'b1, 1'b1);
      bus_wr(7'd1, 16'h0006, 1'b0, 1'b1);
      bus_rd(7'd3, 1'b1, 1'b1, 16'h0550);
      pulse_irq(8'h06);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("ipl_two_src", ipl_n, 3'b010);
      do_iack(3'd5, 8'h41);
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0004);
      @(negedge clk);
      chk("ipl_still_5", ipl_n, 3'b010);
      do_iack(3'd5, 8'h42);
      @(negedge clk);
      chk("ipl_cleared", ipl_n, 3'b111);

      // Spurious: nothing eligible at the acknowledged level, pending untouched
      pulse_irq(8'h02);
      cnt0 = ack_cnt;
      do_iack(3'd3, 8'h18);
      chk("spur_one_pulse", ack_cnt - cnt0, 1);
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0002);
      do_iack(3'd0, 8'h18);
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0002);
      bus_wr(7'd0, 16'h0002, 1'b0, 1'b1);
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0000);

      // Set beats a simultaneous W1C
      @(posedge clk); #1 irq_in = 8'h08;
      bus_wr(7'd0, 16'h0008, 1'b0, 1'b1);
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0008);
      irq_in = 8'h00;
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0008);
      bus_wr(7'd0, 16'h0008, 1'b0, 1'b1);
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0000);

      // VBASE low bits read 0; byte-lane read leaves the other byte alone
      bus_wr(7'd2, 16'h00FF, 1'b0, 1'b1);
      bus_rd(7'd3, 1'b1, 1'b1, 16'h0550);
      bus_rd(7'd2, 1'b0, 1'b1, 16'h05F8);
      bus_rd(7'd1, 1'b1, 1'b1, 16'h0006);

      // Reset while resolving an IACK
      @(posedge clk); #1;
      iack = 1'b1; iack_level = 3'd5;
      cnt0 = ack_cnt;
      @(posedge clk); #1 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mid_no_ack", ack_cnt - cnt0, 0);
      chk("rst_mid_iack_ack", iack_ack, 1'b0);
      chk("rst_mid_vector", vector, 8'h00);
      chk("rst_mid_ipl", ipl_n, 3'b111);
      vec_q.push_back(8'h18);
      reset_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (vec_q.size() == 0) break;
         @(posedge clk); #1;
      end
      if (vec_q.size() != 0) begin
         chk("rst_iack_timeout", vec_q.size(), 0);
         vec_q.delete();
      end
      chk("rst_reresolve", ack_cnt - cnt0, 1);
      #1 iack = 1'b0;
      repeat (2) @(posedge clk);
      bus_rd(7'd0, 1'b1, 1'b1, 16'h0000);
      bus_rd(7'd1, 1'b1, 1'b1, 16'h0000);
      bus_rd(7'd2, 1'b1, 1'b1, 16'h0040);
      bus_rd(7'd3, 1'b1, 1'b1, 16'h0000);
      bus_rd(7'd4, 1'b1, 1'b1, 16'h0000);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
